// File: rtl/osbm.sv
// osbm: per-output-port packet scheduler; one requesting input owns the port from HEAD through TAIL.
// Latency: grant registered one edge after the request is seen; ack is combinational while granted.
// Backpressure: ack/we drop in the same cycle as ofull or empty[g]. Optional macro OSBM_RR_EN selects round-robin.
`ifndef PORT
`define PORT 3
`endif

module osbm #(
    parameter int OUT_ID = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*(`PORT+1)-1:0]    reqs,
    input  logic [`PORT:0]            empty,
    input  logic                      ofull,
    input  logic [1:0]                cmd_sel,
    output logic [`PORT:0]            ack,
    output logic [`PORT:0]            sel,
    output logic                      we,
    output logic                      busy
);
    localparam int N = `PORT + 1;
    localparam logic [1:0] CMD_TAIL = 2'b11;

    typedef enum logic {IDLE, XFER} state_t;

    state_t         state;
    logic [N-1:0]   r;
    logic [N-1:0]   g;
    logic [N-1:0]   pick;
    logic           tail_xfer;

    // Each input's request vector carries one bit per output; take ours.
    always_comb begin
        r = '0;
        for (int i = 0; i < N; i++) begin
            r[i] = reqs[i*N + OUT_ID];
        end
    end

`ifdef OSBM_RR_EN
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] g_idx;
    logic [PW-1:0] next_ptr;

    // Scan from farthest to nearest so the nearest requester at/after ptr wins.
    always_comb begin
        pick = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (r[(int'(ptr) + k) % N]) begin
                pick = '0;
                pick[(int'(ptr) + k) % N] = 1'b1;
            end
        end
    end

    always_comb begin
        g_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (g[i]) g_idx = PW'(i);
        end
    end

    assign next_ptr = (int'(g_idx) == N - 1) ? '0 : g_idx + 1'b1;
`else
    always_comb begin
        pick = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (r[k]) begin
                pick = '0;
                pick[k] = 1'b1;
            end
        end
    end
`endif

    assign ack       = g & ~empty & {N{~ofull}};
    assign we        = |ack;
    assign sel       = g;
    assign busy      = (state == XFER);
    assign tail_xfer = (|ack) && (cmd_sel == CMD_TAIL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            g     <= '0;
`ifdef OSBM_RR_EN
            ptr   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|r) begin
                        g     <= pick;
                        state <= XFER;
                    end
                end
                XFER: begin
                    // Only a TAIL that actually moves releases the port.
                    if (tail_xfer) begin
                        g     <= '0;
                        state <= IDLE;
`ifdef OSBM_RR_EN
                        ptr   <= next_ptr;
`endif
                    end
                end
                default: begin
                    g     <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_osbm.sv
// Directed bench for osbm instantiated on output 2 of the 4-way switch.
module tb_osbm;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] reqs;
    logic [3:0]  empty;
    logic        ofull;
    logic [1:0]  cmd_sel;
    logic [3:0]  ack;
    logic [3:0]  sel;
    logic        we;
    logic        busy;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    localparam logic [1:0] HEAD = 2'b10;
    localparam logic [1:0] BODY = 2'b00;
    localparam logic [1:0] TAIL = 2'b11;

    osbm #(.OUT_ID(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .reqs    (reqs),
        .empty   (empty),
        .ofull   (ofull),
        .cmd_sel (cmd_sel),
        .ack     (ack),
        .sel     (sel),
        .we      (we),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] req_for(input logic [3:0] who);
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < 4; i++) v[i*4 + 2] = who[i];
        return v;
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [3:0] esel,
                              input logic [3:0] eack, input logic ebusy);
        #1;
        chk({tag, "_sel"},  sel,            esel);
        chk({tag, "_ack"},  ack,            eack);
        chk({tag, "_we"},   {3'b000, we},   {3'b000, |eack});
        chk({tag, "_busy"}, {3'b000, busy}, {3'b000, ebusy});
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    logic [3:0] exp_g [4];

    initial begin
`ifdef OSBM_RR_EN
        exp_g = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
`else
        exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
        rst = 1'b1; reqs = '0; empty = '0; ofull = 1'b0; cmd_sel = BODY;
        next_cycle();
        next_cycle();
        expect_out("reset", 4'b0000, 4'b0000, 1'b0);
        rst = 1'b0;

        // Single packet from input 1: HEAD, BODY, BODY, TAIL
        reqs = req_for(4'b0010); cmd_sel = HEAD;
        expect_out("sp_idle", 4'b0000, 4'b0000, 1'b0);
        next_cycle();
        expect_out("sp_head", 4'b0010, 4'b0010, 1'b1);
        next_cycle(); cmd_sel = BODY;
        expect_out("sp_body1", 4'b0010, 4'b0010, 1'b1);
        next_cycle();
        expect_out("sp_body2", 4'b0010, 4'b0010, 1'b1);
        next_cycle(); cmd_sel = TAIL;
        expect_out("sp_tail", 4'b0010, 4'b0010, 1'b1);
        next_cycle(); reqs = '0; cmd_sel = BODY;
        expect_out("sp_done", 4'b0000, 4'b0000, 1'b0);

        // Backpressure on input 3: ofull for three cycles mid-packet
        reqs = req_for(4'b1000); cmd_sel = HEAD;
        next_cycle();
        expect_out("bp_head", 4'b1000, 4'b1000, 1'b1);
        next_cycle(); cmd_sel = BODY; ofull = 1'b1;
        expect_out("bp_stall0", 4'b1000, 4'b0000, 1'b1);
        next_cycle();
        expect_out("bp_stall1", 4'b1000, 4'b0000, 1'b1);
        next_cycle();
        expect_out("bp_stall2", 4'b1000, 4'b0000, 1'b1);
        next_cycle(); ofull = 1'b0;
        expect_out("bp_resume", 4'b1000, 4'b1000, 1'b1);
        next_cycle(); cmd_sel = TAIL;
        expect_out("bp_tail", 4'b1000, 4'b1000, 1'b1);
        next_cycle(); reqs = '0; cmd_sel = BODY;
        expect_out("bp_done", 4'b0000, 4'b0000, 1'b0);

        // Empty stall on input 0 while its TAIL is presented
        reqs = req_for(4'b0001); cmd_sel = HEAD;
        next_cycle(); empty = 4'b1110;
        expect_out("em_head", 4'b0001, 4'b0001, 1'b1);
        next_cycle(); cmd_sel = TAIL; empty = 4'b0001;
        expect_out("em_stall0", 4'b0001, 4'b0000, 1'b1);
        next_cycle();
        expect_out("em_stall1", 4'b0001, 4'b0000, 1'b1);
        next_cycle(); empty = 4'b0000;
        expect_out("em_tail", 4'b0001, 4'b0001, 1'b1);
        next_cycle(); reqs = '0; cmd_sel = BODY;
        expect_out("em_done", 4'b0000, 4'b0000, 1'b0);

        // Reset in the middle of a packet from input 3
        reqs = req_for(4'b1000); cmd_sel = HEAD;
        next_cycle();
        expect_out("rm_head", 4'b1000, 4'b1000, 1'b1);
        next_cycle(); cmd_sel = BODY; reqs = '0; rst = 1'b1;
        expect_out("rm_pre", 4'b1000, 4'b1000, 1'b1);
        next_cycle();
        expect_out("rm_reset", 4'b0000, 4'b0000, 1'b0);
        rst = 1'b0;

        // Contention: inputs 0, 1 and 3 request continuously, 2-flit packets
        reqs = req_for(4'b1011); cmd_sel = HEAD;
        expect_out("ct_idle", 4'b0000, 4'b0000, 1'b0);
        next_cycle();
        for (int p = 0; p < 4; p++) begin
            cmd_sel = HEAD;
            expect_out($sformatf("ct%0d_head", p), exp_g[p], exp_g[p], 1'b1);
            next_cycle(); cmd_sel = TAIL;
            expect_out($sformatf("ct%0d_tail", p), exp_g[p], exp_g[p], 1'b1);
            next_cycle(); cmd_sel = HEAD;
            expect_out($sformatf("ct%0d_gap", p), 4'b0000, 4'b0000, 1'b0);
            next_cycle();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
